// File: rtl/nfc_rdata_checker_pkg.sv
// ============================================================================
// Module  : nfc_chk_pkg
// Brief   : Shared states, pattern modes and the LFSR step for the read checker
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package nfc_chk_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [23:0] ERR_NONE  = 24'hFF_FFFF;

  // Right-shifting Galois form; a non-zero state never reaches zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] i_s);
    lfsr_step = {1'b0, i_s[31:1]} ^ (i_s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nfc_pattern_gen.sv
// ============================================================================
// Module  : nfc_pattern_gen
// Brief   : Seeded expected-data source, one DATA_WIDTH word per accepted beat
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module nfc_pattern_gen
  import nfc_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_mode,
  input  logic [31:0]           i_seed,
  input  logic                  i_advance,
  output logic [DATA_WIDTH-1:0] o_expected
);

  localparam int LANES = (DATA_WIDTH + 31) / 32;

  logic                  r_mode;
  logic [31:0]           r_word;
  logic [31:0]           w_lfsr [LANES+1];
  logic [LANES*32-1:0]   w_full;

  assign w_lfsr[0] = r_word;

  // Lane k sees the LFSR stepped k times beyond the lane-0 word of this beat.
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_lfsr[k+1]      = lfsr_step(w_lfsr[k]);
      assign w_full[k*32 +: 32] = (r_mode == MODE_LFSR) ? w_lfsr[k] : (r_word + 32'(k));
    end
  endgenerate

  assign o_expected = w_full[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_INC;
      r_word <= 32'h0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_word <= ((i_mode == MODE_LFSR) && (i_seed == 32'h0)) ? 32'h1 : i_seed;
    end else if (i_advance) begin
      r_word <= (r_mode == MODE_LFSR) ? w_lfsr[LANES] : (r_word + 32'(LANES));
    end
  end

endmodule

`default_nettype wire

// File: rtl/nfc_rdata_checker.sv
// ============================================================================
// Module  : nfc_rdata_checker
// Brief   : Checks channel read stream against a seeded pattern, reports summary
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module nfc_rdata_checker
  import nfc_chk_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [23:0]             i_len,
  input  logic                    i_mode,
  input  logic [31:0]             i_seed,
  input  logic                    i_stall,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [15:0]             s_axis_tid,
  input  logic [3:0]              s_axis_tuser,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [23:0]             o_byte_cnt,
  output logic [15:0]             o_err_cnt,
  output logic [23:0]             o_first_err,
  output logic                    o_len_err,
  output logic                    o_timeout,
  output logic [15:0]             o_tid,
  output logic [3:0]              o_tuser
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  state_t                r_state;
  logic [23:0]           r_len;
  logic [24:0]           r_cnt;
  logic [23:0]           r_beat;
  logic [15:0]           r_err_cnt;
  logic [23:0]           r_first_err;
  logic                  r_len_err;
  logic                  r_timeout;
  logic [15:0]           r_tid;
  logic [3:0]            r_tuser;
  logic [IW-1:0]         r_idle;

  logic                  w_accept;
  logic                  w_load;
  logic                  w_mis;
  logic [3:0]            w_pop;
  logic [24:0]           w_sum;
  logic [24:0]           w_cnt_next;
  logic [DATA_WIDTH-1:0] w_expected;

  assign s_axis_tready = (r_state == CHECK) && !i_stall;
  assign w_accept      = s_axis_tready && s_axis_tvalid;
  assign w_load        = (r_state == IDLE) && i_start;

  nfc_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pattern (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_mode     (i_mode),
    .i_seed     (i_seed),
    .i_advance  (w_accept),
    .o_expected (w_expected)
  );

  always_comb begin
    w_pop = 4'd0;
    w_mis = 1'b0;
    for (int i = 0; i < KW; i++) begin
      w_pop = w_pop + {3'd0, s_axis_tkeep[i]};
      if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != w_expected[8*i +: 8]))
        w_mis = 1'b1;
    end
  end

  // Bit 24 is sticky so a wrapped 24-bit count can never alias i_len.
  assign w_sum      = {1'b0, r_cnt[23:0]} + 25'(w_pop);
  assign w_cnt_next = {r_cnt[24] | w_sum[24], w_sum[23:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= 24'h0;
      r_cnt       <= 25'h0;
      r_beat      <= 24'h0;
      r_err_cnt   <= 16'h0;
      r_first_err <= ERR_NONE;
      r_len_err   <= 1'b0;
      r_timeout   <= 1'b0;
      r_tid       <= 16'h0;
      r_tuser     <= 4'h0;
      r_idle      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_len       <= i_len;
            r_cnt       <= 25'h0;
            r_beat      <= 24'h0;
            r_err_cnt   <= 16'h0;
            r_first_err <= ERR_NONE;
            r_len_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_tid       <= 16'h0;
            r_tuser     <= 4'h0;
            r_idle      <= '0;
            r_state     <= (i_len == 24'h0) ? DONE : CHECK;
          end
        end
        CHECK: begin
          if (w_accept) begin
            r_idle  <= '0;
            r_cnt   <= w_cnt_next;
            r_beat  <= r_beat + 24'd1;
            r_tuser <= r_tuser | s_axis_tuser;
            if (w_mis) begin
              if (r_err_cnt == 16'h0)    r_first_err <= r_beat;
              if (r_err_cnt != 16'hFFFF) r_err_cnt   <= r_err_cnt + 16'd1;
            end
            if (s_axis_tlast) begin
              r_tid     <= s_axis_tid;
              r_len_err <= r_len_err || (w_cnt_next != {1'b0, r_len});
              r_state   <= DONE;
            end else if (w_cnt_next > {1'b0, r_len}) begin
              r_len_err <= 1'b1;
            end
          end else if (r_idle == IW'(TIMEOUT_CYC - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state == CHECK);
  assign o_done      = (r_state == DONE);
  assign o_byte_cnt  = r_cnt[23:0];
  assign o_err_cnt   = r_err_cnt;
  assign o_first_err = r_first_err;
  assign o_len_err   = r_len_err;
  assign o_timeout   = r_timeout;
  assign o_tid       = r_tid;
  assign o_tuser     = r_tuser;

endmodule

`default_nettype wire

// File: tb/tb_nfc_rdata_checker.sv
// ============================================================================
// Module  : tb_nfc_rdata_checker
// Brief   : Directed self-checking bench for nfc_rdata_checker
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nfc_rdata_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [23:0] i_len;
  logic        i_mode;
  logic [31:0] i_seed;
  logic        i_stall;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic [15:0] s_axis_tid;
  logic [3:0]  s_axis_tuser;
  logic        o_busy;
  logic        o_done;
  logic [23:0] o_byte_cnt;
  logic [15:0] o_err_cnt;
  logic [23:0] o_first_err;
  logic        o_len_err;
  logic        o_timeout;
  logic [15:0] o_tid;
  logic [3:0]  o_tuser;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  nfc_rdata_checker #(
    .DATA_WIDTH  (32),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_len         (i_len),
    .i_mode        (i_mode),
    .i_seed        (i_seed),
    .i_stall       (i_stall),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tuser  (s_axis_tuser),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_byte_cnt    (o_byte_cnt),
    .o_err_cnt     (o_err_cnt),
    .o_first_err   (o_first_err),
    .o_len_err     (o_len_err),
    .o_timeout     (o_timeout),
    .o_tid         (o_tid),
    .o_tuser       (o_tuser)
  );

  always @(negedge clk) if (o_done === 1'b1) done_pulses++;

  function automatic logic [31:0] exp_word(input logic m, input logic [31:0] s, input int n);
    logic [31:0] w;
    if (!m) return s + 32'(n);
    w = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < n; i++) w = w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
    return w;
  endfunction

  task automatic start_run(input logic [23:0] len, input logic m, input logic [31:0] seed);
    i_len = len; i_mode = m; i_seed = seed; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [15:0] id, input logic [3:0] u);
    logic ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k;
    s_axis_tlast = l; s_axis_tid = id; s_axis_tuser = u;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL beat_accept: tready never seen, required 1"); end
  endtask

  task automatic test_reset();
    checks += 4;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b required 00", o_busy, o_done); end
    if (o_byte_cnt !== 24'h0 || o_err_cnt !== 16'h0) begin errors++; $display("FAIL reset_counts: got %h/%h required 0/0", o_byte_cnt, o_err_cnt); end
    if (o_first_err !== 24'hFFFFFF) begin errors++; $display("FAIL reset_first_err: got %h required ffffff", o_first_err); end
    if (o_len_err !== 1'b0 || o_timeout !== 1'b0 || o_tid !== 16'h0 || o_tuser !== 4'h0)
      begin errors++; $display("FAIL reset_status: got %b %b %h %h required 0 0 0 0", o_len_err, o_timeout, o_tid, o_tuser); end
  endtask

  task automatic test_clean_inc();
    int p0;
    p0 = done_pulses;
    start_run(24'd16, 1'b0, 32'h1000);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL inc_busy: got %b required 1", o_busy); end
    for (int n = 0; n < 4; n++)
      send_beat(exp_word(1'b0, 32'h1000, n), 4'hF, n == 3, 16'h1230 + 16'(n), (n == 1) ? 4'h2 : ((n == 3) ? 4'h8 : 4'h0));
    checks += 5;
    if (o_done !== 1'b1) begin errors++; $display("FAIL inc_done: got %b required 1", o_done); end
    if (o_byte_cnt !== 24'd16) begin errors++; $display("FAIL inc_byte_cnt: got %0d required 16", o_byte_cnt); end
    if (o_err_cnt !== 16'd0 || o_first_err !== 24'hFFFFFF) begin errors++; $display("FAIL inc_err: got %0d/%h required 0/ffffff", o_err_cnt, o_first_err); end
    if (o_len_err !== 1'b0) begin errors++; $display("FAIL inc_len_err: got %b required 0", o_len_err); end
    if (o_tid !== 16'h1233 || o_tuser !== 4'hA) begin errors++; $display("FAIL inc_tid_tuser: got %h/%h required 1233/a", o_tid, o_tuser); end
    @(posedge clk); #1;
    checks += 2;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL inc_done_clear: got %b%b required 00", o_done, o_busy); end
    if (done_pulses - p0 !== 1) begin errors++; $display("FAIL inc_done_once: got %0d pulses required 1", done_pulses - p0); end
  endtask

  task automatic test_lfsr_errors();
    logic [31:0] d;
    start_run(24'd64, 1'b1, 32'h0000ACE1);
    for (int n = 0; n < 16; n++) begin
      d = exp_word(1'b1, 32'h0000ACE1, n);
      if (n == 5 || n == 9) d = d ^ 32'h0000FF00;
      send_beat(d, 4'hF, n == 15, 16'h0007, 4'h0);
    end
    checks += 3;
    if (o_err_cnt !== 16'd2) begin errors++; $display("FAIL lfsr_err_cnt: got %0d required 2", o_err_cnt); end
    if (o_first_err !== 24'd5) begin errors++; $display("FAIL lfsr_first_err: got %0d required 5", o_first_err); end
    if (o_byte_cnt !== 24'd64 || o_len_err !== 1'b0) begin errors++; $display("FAIL lfsr_len: got %0d/%b required 64/0", o_byte_cnt, o_len_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_len_err();
    start_run(24'd16, 1'b0, 32'h20);
    for (int n = 0; n < 3; n++) send_beat(exp_word(1'b0, 32'h20, n), 4'hF, n == 2, 16'h0, 4'h0);
    checks += 2;
    if (o_len_err !== 1'b1) begin errors++; $display("FAIL short_len_err: got %b required 1", o_len_err); end
    if (o_byte_cnt !== 24'd12) begin errors++; $display("FAIL short_byte_cnt: got %0d required 12", o_byte_cnt); end
    @(posedge clk); #1;
    start_run(24'd16, 1'b0, 32'h20);
    for (int n = 0; n < 5; n++) send_beat(exp_word(1'b0, 32'h20, n), 4'hF, 1'b0, 16'h0, 4'h0);
    checks++;
    if (o_len_err !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL long_sticky: got len_err %b busy %b required 1 1", o_len_err, o_busy); end
    send_beat(exp_word(1'b0, 32'h20, 5), 4'hF, 1'b1, 16'h0, 4'h0);
    checks++;
    if (o_len_err !== 1'b1 || o_byte_cnt !== 24'd24) begin errors++; $display("FAIL long_len_err: got %b/%0d required 1/24", o_len_err, o_byte_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_tkeep();
    start_run(24'd14, 1'b0, 32'h300);
    for (int n = 0; n < 3; n++) send_beat(exp_word(1'b0, 32'h300, n), 4'hF, 1'b0, 16'h0, 4'h0);
    send_beat(exp_word(1'b0, 32'h300, 3) ^ 32'hABCD0000, 4'b0011, 1'b1, 16'h0, 4'h0);
    checks += 2;
    if (o_err_cnt !== 16'd0 || o_byte_cnt !== 24'd14) begin errors++; $display("FAIL tkeep_counts: got %0d/%0d required 0/14", o_err_cnt, o_byte_cnt); end
    if (o_len_err !== 1'b0) begin errors++; $display("FAIL tkeep_len_err: got %b required 0", o_len_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len();
    start_run(24'd0, 1'b0, 32'h0);
    checks += 2;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL zero_done: got done %b busy %b required 1 0", o_done, o_busy); end
    if (o_byte_cnt !== 24'd0 || o_len_err !== 1'b0) begin errors++; $display("FAIL zero_status: got %0d/%b required 0/0", o_byte_cnt, o_len_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int n;
    start_run(24'd64, 1'b0, 32'h0);
    send_beat(32'h0, 4'hF, 1'b0, 16'h0, 4'h0);
    send_beat(32'h1, 4'hF, 1'b0, 16'h0, 4'h0);
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (o_done === 1'b1) break;
    end
    checks += 2;
    if (n !== 100) begin errors++; $display("FAIL timeout_latency: got %0d cycles required 100", n); end
    if (o_timeout !== 1'b1 || o_byte_cnt !== 24'd8) begin errors++; $display("FAIL timeout_status: got %b/%0d required 1/8", o_timeout, o_byte_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_check();
    int acc;
    int p0;
    start_run(24'd64, 1'b0, 32'h55);
    acc = 0;
    for (int c = 0; c < 300 && acc < 5; c++) begin
      i_stall = ($urandom_range(0, 3) == 0);
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata = exp_word(1'b0, 32'h55, acc); s_axis_tkeep = 4'hF;
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) acc++;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0; i_stall = 1'b0;
    checks++;
    if (o_byte_cnt !== 24'd20 || o_err_cnt !== 16'd0 || o_busy !== 1'b1)
      begin errors++; $display("FAIL stall_progress: got %0d/%0d/%b required 20/0/1", o_byte_cnt, o_err_cnt, o_busy); end
    p0 = done_pulses;
    rst = 1'b1; #1;
    test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (done_pulses !== p0) begin errors++; $display("FAIL reset_no_done: got %0d pulses required 0", done_pulses - p0); end
    start_run(24'd8, 1'b1, 32'h0);
    send_beat(32'h0000_0001, 4'hF, 1'b0, 16'h0, 4'h0);
    send_beat(32'h8020_0003, 4'hF, 1'b1, 16'hBEEF, 4'h1);
    checks += 2;
    if (o_done !== 1'b1 || o_err_cnt !== 16'd0 || o_len_err !== 1'b0)
      begin errors++; $display("FAIL post_reset_run: got done %b err %0d len_err %b required 1 0 0", o_done, o_err_cnt, o_len_err); end
    if (o_tid !== 16'hBEEF || o_tuser !== 4'h1) begin errors++; $display("FAIL post_reset_tid: got %h/%h required beef/1", o_tid, o_tuser); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_len = 24'h0; i_mode = 1'b0; i_seed = 32'h0; i_stall = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 32'h0; s_axis_tkeep = 4'h0; s_axis_tlast = 1'b0;
    s_axis_tid = 16'h0; s_axis_tuser = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_clean_inc();
    test_lfsr_errors();
    test_len_err();
    test_tkeep();
    test_zero_len();
    test_timeout();
    test_reset_mid_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
